freelist_return_arbiter: RTL

//  Merges freed physical tags from two sources into the freelist's N-wide return port (RetireEN/RetireReg).
//  - Retire: old tags of committing instructions.
//  - Squash: new tags of squashed instructions.

---
 rtl/freelist_return_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/freelist_return_arbiter.sv
// Merges retire and squash tag batches into the freelist return port via a small FIFO.
// Optional FREELIST_RET_ZERO_FILTER_EN drops tag-0 lanes and counts them in zero_drop_cnt.
module freelist_return_arbiter #(
  parameter  int N        = 2,
  parameter  int PR_COUNT = 64,
  parameter  int DEPTH    = 8,
  localparam int TW       = $clog2(PR_COUNT),
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N-1:0]         ret_valid,
  input  logic [N-1:0][TW-1:0] ret_tag,
  output logic                 ret_ready,
  input  logic [N-1:0]         sq_valid,
  input  logic [N-1:0][TW-1:0] sq_tag,
  output logic                 sq_ready,
  input  logic                 recover,
  output logic [N-1:0]         RetireEN,
  output logic [N-1:0][TW-1:0] RetireReg,
  output logic [CW-1:0]        occupancy,
  output logic [7:0]           zero_drop_cnt
);

  if (DEPTH < 2 * N) begin : g_depth_chk
    $error("freelist_return_arbiter: DEPTH must be >= 2*N");
  end

  function automatic int popcnt(input logic [N-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += int'(m[i]);
    return c;
  endfunction

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int inc);
    return PW'((int'(p) + inc) % DEPTH);
  endfunction

  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic          rr_ptr;
  logic [TW-1:0] fifo [DEPTH];

  logic [N-1:0]  ret_m, sq_m;
  logic          contend, ret_acc, sq_acc;
  int            pr, ps, free_n, k, enq_n;
  logic [TW-1:0] enq_tag [2*N];

`ifdef FREELIST_RET_ZERO_FILTER_EN
  logic [N-1:0] ret_z, sq_z;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input int inc);
    int s;
    s = int'(a) + inc;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ret_z[i] = ret_valid[i] && (ret_tag[i] == '0);
      sq_z[i]  = sq_valid[i] && (sq_tag[i] == '0);
    end
    ret_m = ret_valid & ~ret_z;
    sq_m  = sq_valid & ~sq_z;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_drop_cnt <= '0;
    end else if (!recover) begin
      zero_drop_cnt <= sat_add8(zero_drop_cnt,
                                (ret_acc ? popcnt(ret_z) : 0) + (sq_acc ? popcnt(sq_z) : 0));
    end
  end
`else
  assign ret_m         = ret_valid;
  assign sq_m          = sq_valid;
  assign zero_drop_cnt = '0;
`endif

  // Admission: free space ignores this cycle's dequeue; contention goes to rr_ptr's source only
  always_comb begin
    pr        = popcnt(ret_m);
    ps        = popcnt(sq_m);
    free_n    = DEPTH - int'(count);
    contend   = 1'b0;
    ret_ready = 1'b0;
    sq_ready  = 1'b0;
    if (!recover) begin
      if (pr + ps <= free_n) begin
        ret_ready = 1'b1;
        sq_ready  = 1'b1;
      end else begin
        contend = 1'b1;
        if (!rr_ptr) ret_ready = (pr <= free_n);
        else         sq_ready  = (ps <= free_n);
      end
    end
    ret_acc = ret_ready && (ret_valid != '0);
    sq_acc  = sq_ready && (sq_valid != '0);
  end

  always_comb begin
    k = (int'(count) < N) ? int'(count) : N;
    for (int i = 0; i < N; i++) begin
      RetireEN[i]  = (i < k) && !recover;
      RetireReg[i] = (i < k) ? fifo[ptr_add(head, i)] : '0;
    end
  end

  // Compaction: accepted retire lanes first, then squash lanes, invalid lanes skipped
  always_comb begin
    for (int j = 0; j < 2 * N; j++) enq_tag[j] = '0;
    enq_n = 0;
    for (int i = 0; i < N; i++) begin
      if (ret_acc && ret_m[i]) begin
        enq_tag[enq_n] = ret_tag[i];
        enq_n++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (sq_acc && sq_m[i]) begin
        enq_tag[enq_n] = sq_tag[i];
        enq_n++;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      rr_ptr <= 1'b0;
    end else if (recover) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      rr_ptr <= 1'b0;
    end else begin
      count <= CW'(int'(count) + enq_n - k);
      head  <= ptr_add(head, k);
      tail  <= ptr_add(tail, enq_n);
      if (contend && (rr_ptr ? sq_acc : ret_acc)) rr_ptr <= ~rr_ptr;
    end
  end

  always_ff @(posedge clock) begin
    if (!recover) begin
      for (int j = 0; j < 2 * N; j++) begin
        if (j < enq_n) fifo[ptr_add(tail, j)] <= enq_tag[j];
      end
    end
  end

  assign occupancy = count;

endmodule
